// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the client request/response bus and the SRAM-side bus of the
//   arbiter so they can travel as one port.
//   slave  : arbiter view (requests and memory status in, grants/strobes out)
//   master : environment view (clients plus the memory model)
//   Clients use packed vectors: client k owns bit k of the per-client flags
//   and slice [k*width +: width] of req_addr / req_data.
interface sram_arbiter_if #(
    parameter int n_clients  = 4,
    parameter int data_width = 16,
    parameter int addr_width = 13
);
    logic [n_clients-1:0]            req_valid;
    logic [n_clients-1:0]            req_write;
    logic [n_clients*addr_width-1:0] req_addr;
    logic [n_clients*data_width-1:0] req_data;
    logic [n_clients-1:0]            req_ready;
    logic [n_clients-1:0]            resp_valid;
    logic [data_width-1:0]           resp_data;
    logic                            resp_error;

    logic                            sram_read;
    logic                            sram_write;
    logic [addr_width-1:0]           sram_read_addr;
    logic [addr_width-1:0]           sram_write_addr;
    logic [data_width-1:0]           sram_data_in;
    logic [data_width-1:0]           sram_data_out;
    logic                            sram_read_ready;
    logic                            sram_write_ready;
    logic                            sram_invalid_read;
    logic                            sram_invalid_write;

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        input  sram_data_out, sram_read_ready, sram_write_ready,
        input  sram_invalid_read, sram_invalid_write,
        output req_ready, resp_valid, resp_data, resp_error,
        output sram_read, sram_write, sram_read_addr, sram_write_addr, sram_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_data,
        output sram_data_out, sram_read_ready, sram_write_ready,
        output sram_invalid_read, sram_invalid_write,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  sram_read, sram_write, sram_read_addr, sram_write_addr, sram_data_in
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin arbiter giving n_clients requesters single-transaction access
//   to one SRAM port. One transaction is in flight at a time.
//   Ports:
//     clk   - sole clock, rising edge
//     reset - asynchronous, active-high; aborts any transaction silently
//     bus   - sram_arbiter_if.slave: client req/resp handshake and SRAM bus
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; grant + latch in the same cycle
//   ISSUE | waiting for memory idle, then strobe read/write once
//   WAIT  | memory busy; first cycle is mandatory (write strobe 2nd cycle)
//   RESP  | one-cycle completion strobe to the granted client
module sram_arbiter #(
    parameter int n_clients  = 4,
    parameter int data_width = 16,
    parameter int addr_width = 13
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam int PTR_W = (n_clients > 1) ? $clog2(n_clients) : 1;
    localparam logic [PTR_W:0]         N_L = (PTR_W + 1)'(n_clients);
    localparam logic [n_clients-1:0]   ONE = n_clients'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_grant;
    logic                  r_write;
    logic                  r_first;
    logic                  r_err;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_data;
    logic [data_width-1:0] r_resp_data;

    logic [n_clients-1:0]  w_rot;
    logic                  w_any;
    logic [PTR_W-1:0]      w_off;
    logic [PTR_W:0]        w_sum;
    logic [PTR_W-1:0]      w_grant;
    logic [PTR_W:0]        w_ptr_sum;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_sel_write;
    logic [addr_width-1:0] w_sel_addr;
    logic [data_width-1:0] w_sel_data;
    logic                  w_mem_ready;
    logic                  w_accept;
    logic                  w_wait_done;

    // Rotate the request vector so bit 0 is the client at the pointer; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    always_comb begin
        w_rot = n_clients'({bus.req_valid, bus.req_valid} >> r_ptr);
        w_any = |w_rot;
        w_off = '0;
        for (int i = n_clients - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = PTR_W'(i);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= N_L) w_sum = w_sum - N_L;
        w_grant = w_sum[PTR_W-1:0];

        w_ptr_sum = {1'b0, w_grant} + 1'b1;
        if (w_ptr_sum >= N_L) w_ptr_sum = w_ptr_sum - N_L;
        w_ptr_nxt = w_ptr_sum[PTR_W-1:0];

        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        for (int i = 0; i < n_clients; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*addr_width +: addr_width];
                w_sel_data  = bus.req_data[i*data_width +: data_width];
            end
        end
    end

    assign w_mem_ready = r_write ? bus.sram_write_ready : bus.sram_read_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_wait_done    = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.resp_error = 1'b0;
        bus.sram_read  = 1'b0;
        bus.sram_write = 1'b0;
        case (r_state)
            IDLE: begin
                // ready is combinational on req_valid, so mask it while reset
                // is held to keep every output at 0.
                if (w_any && !reset) begin
                    w_accept      = 1'b1;
                    bus.req_ready = ONE << w_grant;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (w_mem_ready) begin
                    bus.sram_read  = !r_write;
                    bus.sram_write = r_write;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                bus.sram_write = r_write && r_first;
                // The first WAIT cycle still sees the ready the memory had
                // before it noticed the strobe, so it never ends the wait.
                if (!r_first && w_mem_ready) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = ONE << r_grant;
                bus.resp_error = r_err;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_write     <= 1'b0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant;
                r_ptr   <= w_ptr_nxt;
                r_write <= w_sel_write;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_err   <= 1'b0;
            end
            r_first <= (r_state == ISSUE) && w_mem_ready;
            if ((r_state == WAIT) && (bus.sram_invalid_read || bus.sram_invalid_write))
                r_err <= 1'b1;
            if (w_wait_done && !r_write)
                r_resp_data <= bus.sram_data_out;
        end
    end

    assign bus.sram_read_addr  = r_addr;
    assign bus.sram_write_addr = r_addr;
    assign bus.sram_data_in    = r_data;
    assign bus.resp_data       = r_resp_data;
endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    localparam int N         = 4;
    localparam int DW        = 16;
    localparam int AW        = 14;
    localparam int MEM_WORDS = 8192;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.n_clients(N), .data_width(DW), .addr_width(AW)) bus ();

    sram_arbiter #(.n_clients(N), .data_width(DW), .addr_width(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] env_mem [MEM_WORDS];
    logic [DW-1:0] mdl_mem [MEM_WORDS];

    // ---------------- memory environment ----------------
    logic          n_rd, n_wr, n_resp;
    logic [AW-1:0] n_ra, n_wa;
    logic [DW-1:0] n_wd;
    logic          env_have;
    logic [AW-1:0] env_addr;

    initial forever begin
        @(negedge clk);
        n_rd   = bus.sram_read;
        n_wr   = bus.sram_write;
        n_ra   = bus.sram_read_addr;
        n_wa   = bus.sram_write_addr;
        n_wd   = bus.sram_data_in;
        n_resp = |bus.resp_valid;
    end

    initial begin
        bus.sram_invalid_read  = 1'b0;
        bus.sram_invalid_write = 1'b0;
        env_have = 1'b0;
        env_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.sram_invalid_read  = 1'b0;
                bus.sram_invalid_write = 1'b0;
                env_have = 1'b0;
            end else begin
                bus.sram_invalid_read  = n_rd && (int'(n_ra) >= MEM_WORDS);
                bus.sram_invalid_write = n_wr && (int'(n_wa) >= MEM_WORDS);
                if (n_wr && int'(n_wa) < MEM_WORDS) env_mem[n_wa[12:0]] = n_wd;
                if (n_rd) begin
                    env_have = 1'b1;
                    env_addr = n_ra;
                end else if (n_resp) begin
                    env_have = 1'b0;
                end
            end
        end
    end

    // Read data is only meaningful once a read strobe has reached the memory.
    assign bus.sram_data_out = (env_have && int'(env_addr) < MEM_WORDS) ?
                               env_mem[env_addr[12:0]] : 16'h0BAD;

    // ---------------- behavioural reference model ----------------
    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Transaction-level model: a transaction is tracked by the cycle numbers
    // of its accept (m_t), strobe (m_s) and wait exit (m_e) events.
    int            m_c, m_ptr, m_g, m_t, m_s, m_e;
    bit            m_busy, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    initial begin
        m_c = 0; m_ptr = 0; m_busy = 0;
        m_g = 0; m_t = 0; m_s = -1; m_e = -1; m_wr = 0;
        m_addr = '0; m_data = '0;
        forever begin
            logic [N-1:0]  e_ready, e_resp;
            logic          e_rd, e_wr, e_err, rel;
            logic [DW-1:0] e_rdata;
            bit            chk_addr, chk_rdata;
            int            g;
            @(negedge clk);
            if (reset) begin
                m_busy = 0;
                m_ptr  = 0;
            end else begin
                m_c++;
                e_ready = '0; e_resp = '0; e_rd = 0; e_wr = 0; e_err = 0;
                e_rdata = '0; chk_addr = 0; chk_rdata = 0;
                if (!m_busy) begin
                    g = first_from(bus.req_valid, m_ptr);
                    if (g >= 0) begin
                        e_ready = N'(1) << g;
                        m_busy  = 1;
                        m_g     = g;
                        m_t     = m_c;
                        m_s     = -1;
                        m_e     = -1;
                        m_wr    = bus.req_write[g];
                        m_addr  = bus.req_addr[g*AW +: AW];
                        m_data  = bus.req_data[g*DW +: DW];
                        m_ptr   = (g + 1) % N;
                    end
                end else begin
                    rel = m_wr ? bus.sram_write_ready : bus.sram_read_ready;
                    if (m_s < 0) begin
                        chk_addr = 1;
                        if (rel) begin
                            m_s = m_c;
                            if (m_wr) e_wr = 1; else e_rd = 1;
                        end
                    end else if (m_e < 0) begin
                        chk_addr = 1;
                        if (m_wr && m_c == m_s + 1) e_wr = 1;
                        if (m_c >= m_s + 2 && rel) m_e = m_c;
                    end else begin
                        e_resp    = N'(1) << m_g;
                        e_err     = int'(m_addr) >= MEM_WORDS;
                        chk_rdata = !m_wr && !e_err;
                        if (!e_err) e_rdata = mdl_mem[m_addr[12:0]];
                        if (m_wr && !e_err) mdl_mem[m_addr[12:0]] = m_data;
                        m_busy = 0;
                    end
                end
                chk("m_req_ready", bus.req_ready, e_ready);
                chk("m_sram_read", bus.sram_read, e_rd);
                chk("m_sram_write", bus.sram_write, e_wr);
                chk("m_resp_valid", bus.resp_valid, e_resp);
                chk("m_resp_error", bus.resp_error, e_err);
                if (chk_addr) begin
                    chk("m_read_addr", bus.sram_read_addr, m_addr);
                    chk("m_write_addr", bus.sram_write_addr, m_addr);
                    if (m_wr) chk("m_data_in", bus.sram_data_in, m_data);
                end
                if (chk_rdata) chk("m_resp_data", bus.resp_data, e_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[k] = wr;
        bus.req_addr[k*AW +: AW] = a;
        bus.req_data[k*DW +: DW] = d;
    endtask

    int            gcyc [$];
    logic [N-1:0]  gval [$];
    logic [N-1:0]  exp_order [5];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            env_mem[i] = DW'(i * 37 + 11);
            mdl_mem[i] = DW'(i * 37 + 11);
        end
        env_mem[16'h0105] = 16'hBEEF; mdl_mem[16'h0105] = 16'hBEEF;
        env_mem[16'h0010] = 16'hA5A5; mdl_mem[16'h0010] = 16'hA5A5;

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.sram_read_ready  = 1'b1;
        bus.sram_write_ready = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k + 1), DW'(16'h1000 + k));
        bus.req_valid = 4'b1111;

        // reset state, with every client already requesting
        repeat (3) @(posedge clk);
        to_neg();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_sram_read", bus.sram_read, 0);
        chk("rst_sram_write", bus.sram_write, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_read_addr", bus.sram_read_addr, 0);

        // fairness: continuous requests from reset
        to_drive();
        reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            to_neg();
            if (bus.req_ready != 0) begin
                gval.push_back(bus.req_ready);
                gcyc.push_back(c);
            end
        end
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        chk("fair_count", gval.size(), 5);
        for (int i = 0; i < gval.size() && i < 5; i++) begin
            chk("fair_grant", gval[i], exp_order[i]);
            chk("fair_cycle", gcyc[i], 5 * i);
        end
        to_drive();
        bus.req_valid = '0;
        repeat (6) to_neg();

        // read: client 2, 0x0105 -> 0xBEEF
        to_drive();
        set_req(2, 1'b0, 14'h0105, 16'h7777);
        bus.req_valid = 4'b0100;
        to_neg(); chk("rd_accept", bus.req_ready, 4'b0100);
        to_drive(); bus.req_valid = '0;
        to_neg(); chk("rd_strobe_t1", bus.sram_read, 1);
        chk("rd_addr_t1", bus.sram_read_addr, 14'h0105);
        to_neg(); chk("rd_strobe_t2", bus.sram_read, 0);
        to_neg(); chk("rd_strobe_t3", bus.sram_read, 0);
        to_neg(); chk("rd_resp_valid", bus.resp_valid, 4'b0100);
        chk("rd_resp_data", bus.resp_data, 16'hBEEF);
        chk("rd_resp_error", bus.resp_error, 0);

        // write 0x1234 to 0x0003 by client 0, then read it back by client 1
        to_drive();
        set_req(0, 1'b1, 14'h0003, 16'h1234);
        bus.req_valid = 4'b0001;
        to_neg(); chk("wr_accept", bus.req_ready, 4'b0001);
        to_drive(); bus.req_valid = '0;
        to_neg(); chk("wr_strobe_t1", bus.sram_write, 1);
        chk("wr_data_t1", bus.sram_data_in, 16'h1234);
        to_neg(); chk("wr_strobe_t2", bus.sram_write, 1);
        chk("wr_addr_t2", bus.sram_write_addr, 14'h0003);
        to_neg(); chk("wr_strobe_t3", bus.sram_write, 0);
        chk("wr_data_t3", bus.sram_data_in, 16'h1234);
        to_neg(); chk("wr_resp_valid", bus.resp_valid, 4'b0001);
        to_drive();
        set_req(1, 1'b0, 14'h0003, 16'h0000);
        bus.req_valid = 4'b0010;
        to_neg(); chk("rb_accept", bus.req_ready, 4'b0010);
        to_drive(); bus.req_valid = '0;
        repeat (3) to_neg();
        to_neg(); chk("rb_resp_valid", bus.resp_valid, 4'b0010);
        chk("rb_resp_data", bus.resp_data, 16'h1234);

        // out of range read by client 3
        to_drive();
        set_req(3, 1'b0, 14'h2000, 16'h0000);
        bus.req_valid = 4'b1000;
        to_neg(); chk("oor_accept", bus.req_ready, 4'b1000);
        to_drive(); bus.req_valid = '0;
        repeat (3) to_neg();
        to_neg(); chk("oor_resp_valid", bus.resp_valid, 4'b1000);
        chk("oor_resp_error", bus.resp_error, 1);

        // memory busy during ISSUE for 3 cycles
        to_drive();
        set_req(2, 1'b0, 14'h0010, 16'h0000);
        bus.req_valid = 4'b0100;
        bus.sram_read_ready = 1'b0;
        to_neg(); chk("busy_accept", bus.req_ready, 4'b0100);
        to_drive(); bus.req_valid = '0;
        to_neg(); chk("busy_t1", bus.sram_read, 0);
        to_neg(); chk("busy_t2", bus.sram_read, 0);
        to_neg(); chk("busy_t3", bus.sram_read, 0);
        to_drive(); bus.sram_read_ready = 1'b1;
        to_neg(); chk("busy_strobe", bus.sram_read, 1);
        to_neg(); chk("busy_after", bus.sram_read, 0);
        to_neg();
        to_neg(); chk("busy_resp_valid", bus.resp_valid, 4'b0100);
        chk("busy_resp_data", bus.resp_data, 16'hA5A5);

        // reset during WAIT of a write by client 1 (pointer was moved to 2)
        to_drive();
        set_req(1, 1'b1, 14'h1F00, 16'h5A5A);
        bus.req_valid = 4'b0010;
        to_neg(); chk("rw_accept", bus.req_ready, 4'b0010);
        to_drive(); bus.req_valid = '0;
        to_neg(); chk("rw_strobe_t1", bus.sram_write, 1);
        to_neg(); chk("rw_strobe_t2", bus.sram_write, 1);
        #2;
        bus.req_valid = 4'b1010;
        reset = 1'b1;
        #1;
        chk("rw_rst_write", bus.sram_write, 0);
        chk("rw_rst_ready", bus.req_ready, 0);
        chk("rw_rst_resp", bus.resp_valid, 0);
        chk("rw_rst_waddr", bus.sram_write_addr, 0);
        chk("rw_rst_data_in", bus.sram_data_in, 0);
        chk("rw_rst_resp_data", bus.resp_data, 0);
        to_drive();
        to_drive();
        reset = 1'b0;
        to_neg(); chk("rw_post_grant", bus.req_ready, 4'b0010);
        chk("rw_post_resp", bus.resp_valid, 0);
        to_drive(); bus.req_valid = '0;
        repeat (6) to_neg();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            to_drive();
            for (int k = 0; k < N; k++) begin
                logic [AW-1:0] a;
                if ($urandom_range(0, 9) == 0) a = AW'(MEM_WORDS + $urandom_range(0, MEM_WORDS - 1));
                else                          a = AW'($urandom_range(0, 63));
                set_req(k, 1'($urandom_range(0, 1)), a, DW'($urandom));
            end
            bus.req_valid        = N'($urandom);
            bus.sram_read_ready  = ($urandom_range(0, 3) != 0);
            bus.sram_write_ready = ($urandom_range(0, 3) != 0);
        end
        to_drive();
        bus.req_valid = '0;
        bus.sram_read_ready  = 1'b1;
        bus.sram_write_ready = 1'b1;
        repeat (12) to_neg();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be: n_clients, default 4, number of requesters (2..8); data_width, default 16, word width; addr_width, default 13, word address width.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge except under reset.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  n_clients  per-client request pending.
REQ-005 req_write  input  n_clients  per-client op: 1 = write, 0 = read.
REQ-006 req_addr  input  n_clients*addr_width  packed addresses; client k occupies bits [k*addr_width +: addr_width].
REQ-007 req_data  input  n_clients*data_width  packed write data, same packing.
REQ-008 req_ready  output  n_clients  one-hot accept strobe.
REQ-009 resp_valid  output  n_clients  one-hot completion strobe.
REQ-010 resp_data  output  data_width  read data; valid with resp_valid.
REQ-011 resp_error  output  1  out-of-range flag; valid with resp_valid.
REQ-012 sram_read, sram_write  output  1 each  memory op strobes.
REQ-013 sram_read_addr, sram_write_addr  output  addr_width  memory addresses.
REQ-014 sram_data_in  output  data_width  memory write data.
REQ-015 sram_data_out  input  data_width  memory read data.
REQ-016 sram_read_ready, sram_write_ready  input  1 each  memory idle flags.
REQ-017 sram_invalid_read, sram_invalid_write  input  1 each  memory out-of-range pulses.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; only one transaction SHALL be in flight.
REQ-019 IDLE: if any req_valid is set, the grant SHALL be the first set bit at or after the round-robin pointer (wrapping); req_ready[grant] SHALL be driven combinationally high in that cycle; op, address, data and grant index SHALL be latched; next state ISSUE.
REQ-020 req_ready SHALL be 0 in all states except IDLE; a request dropped before acceptance SHALL be ignored.
REQ-021 After a grant to client k, the pointer SHALL become (k+1) mod n_clients.
REQ-022 ISSUE: if the relevant sram_*_ready is 0, the block SHALL remain in ISSUE with strobes low; otherwise it SHALL assert the relevant strobe for that cycle and go to WAIT.
REQ-023 Reads SHALL assert sram_read for exactly one cycle.
REQ-024 Writes SHALL assert sram_write for exactly two consecutive cycles: ISSUE plus the first WAIT cycle.
REQ-025 Latched address and data SHALL be held stable on sram_* from ISSUE through the end of WAIT.
REQ-026 WAIT: any sram_invalid_read or sram_invalid_write pulse SHALL be sticky-latched as the error flag.
REQ-027 WAIT SHALL exit on the first cycle after the first WAIT cycle in which the relevant sram_*_ready is 1; on that edge sram_data_out SHALL be registered into resp_data for reads; next state RESP.
REQ-028 RESP: resp_valid[grant] SHALL be high for exactly one cycle with resp_data and resp_error; next state IDLE; no new grant SHALL occur in RESP.
REQ-029 resp_data SHALL hold its last value outside RESP; for writes, the value of resp_data is undefined.
REQ-030 With memory idle, the nominal timeline SHALL be: accept at T, strobe at T+1, resp_valid at T+4, next accept possible at T+5.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, pointer 0, and all outputs, latches and the error flag to 0, including mid-transaction.
REQ-032 A transaction interrupted by reset SHALL produce no resp_valid.

Verification
REQ-033 Read: client 2 reads address 0x0105 holding 0xBEEF, memory idle -> req_ready=0b0100 at T, sram_read high only at T+1, resp_valid=0b0100 with resp_data=0xBEEF and resp_error=0 at T+4.
REQ-034 Write then read-back: client 0 writes 0x1234 to 0x0003 -> sram_write high at T+1 and T+2, data stable; a subsequent read of 0x0003 returns 0x1234.
REQ-035 Fairness: all four clients request continuously from reset -> grants in order 0,1,2,3,0, five cycles apart.
REQ-036 Out of range: with addr_width 14 and 8192 words, a read of 0x2000 -> resp_error=1 on resp_valid.
REQ-037 Reset is asserted during WAIT of a write -> outputs 0 asynchronously, no resp_valid, pointer 0; the next grant goes to the lowest requesting client.
REQ-038 Memory busy: hold sram_read_ready at 0 for 3 cycles during ISSUE -> the block stays in ISSUE with sram_read 0, then strobes once when sram_read_ready returns to 1.
